// File: rtl/led_bank_arbiter.sv
// Round-robin owner of the 8-LED bank with a hold limit and a blank cycle between owners.
// Optional idle heartbeat on o_led[0] when LED_ARB_HEARTBEAT_EN is defined.
module led_bank_arbiter #(
    parameter int NREQ     = 4,
    parameter int MIN_HOLD = 4,
    parameter int MAX_HOLD = 16,
    parameter int HB_DIV   = 8000000
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic [NREQ-1:0]   i_req,
    input  logic [8*NREQ-1:0] i_led_data,
    output logic [NREQ-1:0]   o_grant,
    output logic [7:0]        o_led,
    output logic              o_busy
);

    localparam int IDX_W  = $clog2(NREQ);
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD);

    // MIN_HOLD is honoured implicitly because preemption waits for MAX_HOLD >= MIN_HOLD.
    if (NREQ < 2 || NREQ > 8 || MIN_HOLD < 1 || MAX_HOLD < MIN_HOLD || HB_DIV < 2) begin : g_param_check
        $error("led_bank_arbiter: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWNED = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t              state_r;
    logic [IDX_W-1:0]    owner_r;
    logic [IDX_W-1:0]    last_owner_r;
    logic [HOLD_W-1:0]   hold_r;
    logic [NREQ-1:0]     grant_r;
    logic [7:0]          led_r;
    logic                busy_r;

    logic [IDX_W-1:0]    pick_s;
    logic                any_req_s;
    logic                owner_req_s;
    logic                other_req_s;
    logic                release_s;
    logic [7:0]          owner_slice_s;
    logic [7:0]          idle_led_s;

    // First requester at or after last+1, wrapping modulo NREQ.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NREQ-1:0] req,
                                                 input logic [IDX_W-1:0] last);
        logic [IDX_W-1:0] idx;
        logic             found;
        logic             hit;
        rr_pick = last;
        found   = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            idx     = IDX_W'((32'(last) + i) % NREQ);
            hit     = req[idx] & ~found;
            rr_pick = hit ? idx : rr_pick;
            found   = found | hit;
        end
    endfunction

    function automatic logic [NREQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

`ifdef LED_ARB_HEARTBEAT_EN
    localparam int HB_W = $clog2(HB_DIV);

    logic [HB_W-1:0] hb_cnt_r;
    logic            hb_r;
    logic            hb_wrap_s;
    logic            hb_nxt_s;

    // Heartbeat phase after the current edge, so IDLE shows it with no extra lag.
    always_comb begin
        hb_wrap_s  = (hb_cnt_r == HB_W'(HB_DIV - 1));
        hb_nxt_s   = hb_wrap_s ? ~hb_r : hb_r;
        idle_led_s = {7'b0000000, hb_nxt_s};
    end

    // Free-running heartbeat divider, independent of arbitration state.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            hb_cnt_r <= '0;
            hb_r     <= 1'b0;
        end else begin
            hb_cnt_r <= hb_wrap_s ? '0 : hb_cnt_r + 1'b1;
            hb_r     <= hb_nxt_s;
        end
    end
`else
    assign idle_led_s = 8'h00;
`endif

    // Request summaries and the owner's pattern slice.
    always_comb begin
        any_req_s     = |i_req;
        owner_req_s   = |(i_req & grant_r);
        other_req_s   = |(i_req & ~grant_r);
        release_s     = ~owner_req_s | ((hold_r >= HOLD_LIMIT) & other_req_s);
        pick_s        = rr_pick(i_req, last_owner_r);
        owner_slice_s = i_led_data[{owner_r, 3'b000} +: 8];
    end

    // Arbitration FSM with registered grant, LED drive and busy.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_r      <= ST_IDLE;
            owner_r      <= '0;
            last_owner_r <= IDX_W'(NREQ - 1);
            hold_r       <= '0;
            grant_r      <= '0;
            led_r        <= 8'h00;
            busy_r       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_GAP: begin
                    if (any_req_s) begin
                        state_r <= ST_OWNED;
                        owner_r <= pick_s;
                        grant_r <= onehot(pick_s);
                        busy_r  <= 1'b1;
                        hold_r  <= HOLD_W'(1);
                        led_r   <= 8'h00;
                    end else begin
                        state_r <= ST_IDLE;
                        grant_r <= '0;
                        busy_r  <= 1'b0;
                        hold_r  <= '0;
                        led_r   <= (state_r == ST_IDLE) ? idle_led_s : 8'h00;
                    end
                end
                ST_OWNED: begin
                    if (release_s) begin
                        state_r      <= ST_GAP;
                        last_owner_r <= owner_r;
                        grant_r      <= '0;
                        led_r        <= 8'h00;
                        busy_r       <= 1'b0;
                        hold_r       <= '0;
                    end else begin
                        led_r  <= owner_slice_s;
                        hold_r <= (hold_r < HOLD_LIMIT) ? hold_r + 1'b1 : hold_r;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    grant_r <= '0;
                    led_r   <= 8'h00;
                    busy_r  <= 1'b0;
                    hold_r  <= '0;
                end
            endcase
        end
    end

    assign o_grant = grant_r;
    assign o_led   = led_r;
    assign o_busy  = busy_r;

endmodule

// File: tb/tb_led_bank_arbiter.sv
// Randomized and directed bench for led_bank_arbiter against an ownership-level model.
module tb_led_bank_arbiter;
    localparam int NREQ     = 4;
    localparam int MIN_HOLD = 4;
    localparam int MAX_HOLD = 16;
    localparam int HB_DIV   = 8;

    logic              i_clk = 1'b0;
    logic              i_reset_n = 1'b0;
    logic [NREQ-1:0]   i_req = '0;
    logic [8*NREQ-1:0] i_led_data = '0;
    logic [NREQ-1:0]   o_grant;
    logic [7:0]        o_led;
    logic              o_busy;

    int checks = 0;
    int errors = 0;

    // Model: who owns the bank, for how long, and who owned it last.
    int        m_owner = -1;
    bit        m_gap = 1'b0;
    int        m_last = NREQ - 1;
    int        m_held = 0;
    int        m_hb = 0;
    logic [7:0] m_led = 8'h00;

    led_bank_arbiter #(.NREQ(NREQ), .MIN_HOLD(MIN_HOLD), .MAX_HOLD(MAX_HOLD), .HB_DIV(HB_DIV)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_req(i_req), .i_led_data(i_led_data),
        .o_grant(o_grant), .o_led(o_led), .o_busy(o_busy));

    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int next_owner(input logic [NREQ-1:0] req, input int last);
        for (int i = 1; i <= NREQ; i++) begin
            if (req[(last + i) % NREQ]) return (last + i) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [7:0] exp_grant();
        logic [7:0] g = 8'h00;
        if (m_owner >= 0) g[m_owner] = 1'b1;
        return g;
    endfunction

    task automatic model_reset();
        m_owner = -1; m_gap = 1'b0; m_last = NREQ - 1; m_held = 0; m_hb = 0; m_led = 8'h00;
    endtask

    task automatic model_step();
        int others;
        m_hb++;
        if (m_owner >= 0) begin
            others = 0;
            for (int k = 0; k < NREQ; k++) if (k != m_owner && i_req[k]) others++;
            if (!i_req[m_owner] || (m_held >= MAX_HOLD && others > 0)) begin
                m_last = m_owner; m_owner = -1; m_gap = 1'b1; m_held = 0; m_led = 8'h00;
            end else begin
                m_held = (m_held < MAX_HOLD) ? m_held + 1 : MAX_HOLD;
                m_led  = i_led_data[8*m_owner +: 8];
            end
        end else begin
            m_owner = next_owner(i_req, m_last);
            if (m_owner >= 0) begin
                m_held = 1; m_led = 8'h00;
            end else begin
`ifdef LED_ARB_HEARTBEAT_EN
                m_led = m_gap ? 8'h00 : 8'((m_hb / HB_DIV) % 2);
`else
                m_led = 8'h00;
`endif
            end
            m_gap = 1'b0;
        end
    endtask

    initial forever begin
        @(posedge i_clk or negedge i_reset_n);
        if (!i_reset_n) model_reset();
        else model_step();
    end

    // Every-cycle compare against the model on the inactive edge.
    initial forever begin
        @(negedge i_clk);
        if (i_reset_n) begin
            chk("grant", 8'(o_grant), exp_grant());
            chk("led", o_led, m_led);
            chk("busy", 8'(o_busy), 8'(m_owner >= 0));
        end
    end

    task automatic do_reset();
        @(negedge i_clk); #1;
        i_reset_n = 1'b0; i_req = '0;
        repeat (2) @(negedge i_clk);
        #1 i_reset_n = 1'b1;
    endtask

    initial begin
        logic [3:0] g;
        repeat (2) @(negedge i_clk);
        chk("rst_grant", 8'(o_grant), 8'h00);
        chk("rst_led", o_led, 8'h00);
        chk("rst_busy", 8'(o_busy), 8'h00);
        #1 i_reset_n = 1'b1;

        // Single owner with latency and pattern update.
        repeat (3) @(negedge i_clk);
        #1 i_req = 4'b0001; i_led_data = 32'h1122_33A5;
        @(negedge i_clk);
        chk("t1_grant", 8'(o_grant), 8'h01);
        chk("t1_led_first", o_led, 8'h00);
        @(negedge i_clk);
        chk("t1_led", o_led, 8'hA5);
        #1 i_led_data[7:0] = 8'h3C;
        @(negedge i_clk);
        chk("t1_led_chg", o_led, 8'h3C);

        // Full contention: 16-cycle turns with one blank cycle between.
        do_reset();
        i_req = 4'b1111;
        for (int k = 0; k <= 4; k++) begin
            g = 4'b0001 << (k % 4);
            for (int c = 0; c < MAX_HOLD; c++) begin
                @(negedge i_clk);
                chk("t2_grant", 8'(o_grant), 8'(g));
            end
            if (k < 4) begin
                @(negedge i_clk);
                chk("t2_gap_grant", 8'(o_grant), 8'h00);
                chk("t2_gap_led", o_led, 8'h00);
            end
        end

        // Early release in the second owned cycle.
        do_reset();
        i_req = 4'b0010;
        @(negedge i_clk);
        chk("t3_grant1", 8'(o_grant), 8'h02);
        @(negedge i_clk);
        #1 i_req = 4'b1000;
        @(negedge i_clk);
        chk("t3_gap", 8'(o_grant), 8'h00);
        @(negedge i_clk);
        chk("t3_grant3", 8'(o_grant), 8'h08);

        // Lone owner keeps the bank, then is preempted at saturated hold.
        do_reset();
        i_req = 4'b0100;
        for (int c = 0; c < 100; c++) begin
            @(negedge i_clk);
            chk("t4_lone", 8'(o_grant), 8'h04);
        end
        #1 i_req = 4'b0101;
        @(negedge i_clk);
        chk("t4_gap", 8'(o_grant), 8'h00);
        @(negedge i_clk);
        chk("t4_new", 8'(o_grant), 8'h01);

        // Asynchronous reset while owner 2 drives a pattern.
        do_reset();
        i_req = 4'b0100; i_led_data = 32'h0F5A_0000;
        repeat (3) @(negedge i_clk);
        chk("t5_pre_led", o_led, 8'h5A);
        #3 i_reset_n = 1'b0;
        #1;
        chk("t5_grant", 8'(o_grant), 8'h00);
        chk("t5_led", o_led, 8'h00);
        chk("t5_busy", 8'(o_busy), 8'h00);
        @(negedge i_clk);
        #1 i_reset_n = 1'b1; i_req = 4'b1111;
        @(negedge i_clk);
        chk("t5_first", 8'(o_grant), 8'h01);

`ifdef LED_ARB_HEARTBEAT_EN
        do_reset();
        repeat (7) @(negedge i_clk);
        chk("hb_low", o_led, 8'h00);
        @(negedge i_clk);
        chk("hb_high", o_led, 8'h01);
        #1 i_req = 4'b1000;
        repeat (2) @(negedge i_clk);
        chk("hb_override", 8'(o_grant), 8'h08);
`endif

        // Randomized phase with varying request churn.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            @(negedge i_clk);
            #1;
            for (int b = 0; b < NREQ; b++) begin
                if ($urandom_range(((c / 500) % 2 == 0) ? 7 : 31) == 0) i_req[b] = ~i_req[b];
            end
            i_led_data = $urandom;
            if ($urandom_range(1999) == 0) begin
                i_reset_n = 1'b0;
                #2 i_reset_n = 1'b1;
            end
        end

        @(negedge i_clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/led_bank_arbiter.md
Name: led_bank_arbiter

Overview:
- Shares the board's 8-LED bank between NREQ pattern generators (blinky, sine/PWM pattern, status codes).
- Sits between the pattern modules and the top-level LED pin assignments.
- Round-robin arbitration with request/grant handshake, a minimum-hold guarantee and a maximum-hold preemption limit.
- Forces one blank cycle between owners so patterns never mix.

Parameters:
- NREQ, 4, number of requesters (2..8).
- MIN_HOLD, 4, cycles an owner keeps the bank before it can be preempted (>=1).
- MAX_HOLD, 16, cycles after which an owner is preempted if another request is pending (>=MIN_HOLD).
- HB_DIV, 8000000, heartbeat half-period in cycles (optional feature only).

Ports:
- i_clk  input  1  system clock (16 MHz on board).
- i_reset_n  input  1  asynchronous, active-low reset.
- i_req  input  NREQ  request per requester; held high while it wants the bank.
- i_led_data  input  8*NREQ  LED pattern per requester; requester k uses bits [8k+7:8k].
- o_grant  output  NREQ  one-hot grant, registered.
- o_led  output  8  LED bank drive, registered.
- o_busy  output  1  high while any requester owns the bank.

Behaviour:
- Clock and reset: one clock, i_clk. Reset is asynchronous and active-low on i_reset_n.
- Reset values:
  - state=IDLE.
  - o_grant=0, o_led=0, o_busy=0.
  - Hold counter = 0.
  - Last-owner pointer = NREQ-1, so requester 0 wins first.
- States: IDLE, OWNED, GAP.
- IDLE:
  - Any i_req bit high -> OWNED next cycle.
  - Owner = first requester found searching from last_owner+1 upward, modulo NREQ.
- OWNED:
  - o_grant[owner]=1; o_busy=1.
  - Hold counter = 1 in the first OWNED cycle, increments each cycle, saturates at MAX_HOLD.
  - o_led <= owner's i_led_data slice each cycle, so input changes appear on o_led 1 cycle later.
  - Transitions are checked in priority order:
    1. i_req[owner]=0 -> GAP. The owner may release at any time; MIN_HOLD protects only against preemption.
    2. hold >= MAX_HOLD and another i_req bit is high -> GAP (preemption).
    3. Otherwise stay in OWNED. A lone owner keeps the bank indefinitely with no gap.
  - The preemption check uses the MAX_HOLD limit only. MIN_HOLD <= MAX_HOLD, so MIN_HOLD is implicitly honoured.
- On entry to GAP:
  - last_owner <= owner.
  - o_grant=0, o_led=0, o_busy=0.
- GAP:
  - Lasts exactly 1 cycle.
  - Then -> OWNED with a new owner picked by round-robin from last_owner+1 if any i_req bit is high, else -> IDLE.
  - The previous owner can be re-granted only if it is the only requester.
- Latency:
  - Request in cycle t from IDLE -> grant visible at t+1.
  - The owner's pattern is visible on o_led at t+2.
- Simultaneous events:
  - An owner drop and a preemption in the same cycle are handled identically (-> GAP).
  - A request arriving during GAP is considered for the next owner.
- Hold counter width is $clog2(MAX_HOLD+1).
- i_led_data slices of non-owners are ignored.
- Reset asserted mid-operation:
  - All outputs go to 0 immediately (asynchronously).
  - After release, arbitration restarts from requester 0.

Optional Feature:
- Macro: LED_ARB_HEARTBEAT_EN.
- Defined:
  - While in IDLE, o_led[0] toggles every HB_DIV cycles, driven by a free-running divider that is reset to 0.
  - o_led[7:1]=0 in IDLE.
  - OWNED and GAP behaviour is unchanged.
  - The divider counter keeps running in all states.
- Not defined:
  - No divider logic is built.
  - o_led=0 in IDLE.

Test Plan:
All scenarios use NREQ=4, MIN_HOLD=4, MAX_HOLD=16, HB_DIV=8.
1. Single owner: reset, then i_req=0001 with slice0=0xA5 from cycle 10 -> o_grant=0001 at cycle 11; o_led=0xA5 at cycle 12; slice0 changed to 0x3C at cycle 20 -> o_led=0x3C at cycle 21.
2. Full contention: i_req=1111 held -> grants in order 0001, 0010, 0100, 1000, 0001; each held 16 cycles; one cycle with o_grant=0 and o_led=0 between owners.
3. Early release: owner 1, drop i_req[1] in its 2nd cycle with i_req[3] high -> 1-cycle GAP, then o_grant=1000.
4. Lone owner: i_req=0100 for 100 cycles -> o_grant=0100 continuously, no GAP. Raising i_req[0] at that point -> preempted on the next cycle (hold saturated); o_grant=0001 two cycles after i_req[0] rises.
5. Reset mid-operation: assert i_reset_n=0 while owner 2 holds -> o_grant, o_led, o_busy = 0 immediately; after release with i_req=1111, first grant = 0001.
6. With LED_ARB_HEARTBEAT_EN defined and no requests: o_led toggles between 0x00 and 0x01 every 8 cycles; a request from requester 3 overrides it within 2 cycles.
